// File: rtl/fx2_tx_packer.sv
// Buffers fixed-width timetag records and serializes them MSB-first onto the
// FX2 byte handshake, counting bytes handed to USB for length reporting.
module fx2_tx_packer #(
  parameter int WORD_BYTES = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [8*WORD_BYTES-1:0] rec_data,
  input  logic                    rec_valid,
  output logic                    rec_ready,
  output logic [7:0]              fpga_word,
  output logic                    fpga_word_avail,
  input  logic                    fpga_word_accepted,
  input  logic                    request_length,
  output logic [LEN_W-1:0]        length,
  output logic                    overflow
);

  localparam int RW = 8 * WORD_BYTES;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  logic [RW-1:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic             r_recReady;
  logic             r_overflow;
  logic [RW-1:0]    r_shift;
  logic [IW-1:0]    r_idx;
  logic             r_hold;
  logic [LEN_W-1:0] r_count;
  logic [LEN_W-1:0] r_length;

  logic             w_push;
  logic             w_empty;
  logic             w_accept;
  logic             w_lastByte;
  logic             w_pop;
  logic [AW:0]      w_wrPtrNext;
  logic [AW:0]      w_rdPtrNext;
  logic             w_fullNext;
  logic [LEN_W-1:0] w_countInc;

  assign w_push      = rec_valid && r_recReady;
  assign w_empty     = (r_wrPtr == r_rdPtr);
  assign w_accept    = fpga_word_accepted && r_hold;
  assign w_lastByte  = (r_idx == IW'(WORD_BYTES - 1));
  assign w_pop       = !w_empty && (!r_hold || (w_accept && w_lastByte));
  assign w_wrPtrNext = r_wrPtr + (AW+1)'(w_push);
  assign w_rdPtrNext = r_rdPtr + (AW+1)'(w_pop);
  // Full when the pointers differ only in their wrap bit.
  assign w_fullNext  = (w_wrPtrNext[AW] != w_rdPtrNext[AW]) &&
                       (w_wrPtrNext[AW-1:0] == w_rdPtrNext[AW-1:0]);
  assign w_countInc  = (w_accept && (r_count != {LEN_W{1'b1}})) ?
                       r_count + LEN_W'(1) : r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr[AW-1:0]] <= rec_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_recReady <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_wrPtr    <= w_wrPtrNext;
      r_rdPtr    <= w_rdPtrNext;
      r_recReady <= !w_fullNext;
      if (rec_valid && !r_recReady) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // A pop on the last accepted byte reloads the shifter with no idle cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_hold  <= 1'b0;
    end else if (w_pop) begin
      r_shift <= r_mem[r_rdPtr[AW-1:0]];
      r_idx   <= '0;
      r_hold  <= 1'b1;
    end else if (w_accept) begin
      r_shift <= r_shift << 8;
      if (w_lastByte) begin
        r_idx  <= '0;
        r_hold <= 1'b0;
      end else begin
        r_idx  <= r_idx + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count  <= '0;
      r_length <= '0;
    end else if (request_length) begin
      r_length <= w_countInc;
      r_count  <= '0;
    end else begin
      r_count  <= w_countInc;
    end
  end

  assign rec_ready       = r_recReady;
  assign fpga_word       = r_shift[RW-1 -: 8];
  assign fpga_word_avail = r_hold;
  assign length          = r_length;
  assign overflow        = r_overflow;

endmodule
